// File: rtl/axi_err_resp.sv
// axi_err_resp: AXI4 terminating subordinate. Every write and read is accepted
// and completed with a fixed error response, honouring burst length and
// returning responses in acceptance order on each path.

package axi_err_resp_pkg;
  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 64;
  localparam int unsigned UserW = 1;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [5:0]       atop;
    logic [UserW-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
    logic [UserW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [UserW-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

// Small non-fall-through FIFO; full/empty come from the registered occupancy.
module axi_err_resp_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned     CntW     = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DepthCnt);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage: payload only, never reset; outputs are qualified by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module axi_err_resp #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiDataWidth = 64,
  parameter type         axi_req_t    = axi_err_resp_pkg::axi_req_t,
  parameter type         axi_resp_t   = axi_err_resp_pkg::axi_resp_t,
  parameter logic [1:0]  Resp         = 2'b11,
  parameter logic [63:0] RespData     = 64'hCA11AB1EBADCAB1E,
  parameter int unsigned MaxTrans     = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);
  // Fit the constant read data onto the bus: truncate or zero-extend.
  function automatic logic [AxiDataWidth-1:0] fit_resp_data();
    logic [AxiDataWidth-1:0] fit;
    fit = '0;
    for (int i = 0; i < AxiDataWidth; i++) begin
      if (i < 64) fit[i] = RespData[i];
    end
    return fit;
  endfunction

  localparam logic [AxiDataWidth-1:0] RespDataFit = fit_resp_data();

  logic                  aw_full;
  logic                  aw_empty;
  logic [AxiIdWidth-1:0] aw_head_id;
  logic                  aw_push;
  logic                  b_free;
  logic                  w_ready;
  logic                  w_last_hs;
  logic                  b_vld_p1;
  logic [AxiIdWidth-1:0] b_id_p1;

  logic                    ar_full;
  logic                    ar_empty;
  logic [AxiIdWidth+7:0]   ar_head;
  logic [AxiIdWidth-1:0]   ar_head_id;
  logic [7:0]              ar_head_len;
  logic                    ar_push;
  logic [7:0]              r_cnt;
  logic                    r_last;
  logic                    r_hs;
  logic                    unused_req;

  // Everything except handshakes, IDs, ar.len and w.last is deliberately ignored.
  assign unused_req = ^slv_req_i;

  // ---- write path: AW id FIFO -> W drain -> single-entry B register ----
  assign aw_push   = slv_req_i.aw_valid && !aw_full;
  assign b_free    = !b_vld_p1 || slv_req_i.b_ready;
  // Only the closing beat needs room in the B register; earlier beats just drain.
  assign w_ready   = !aw_empty && (!slv_req_i.w.last || b_free);
  assign w_last_hs = slv_req_i.w_valid && w_ready && slv_req_i.w.last;

  axi_err_resp_fifo #(.Width(AxiIdWidth), .Depth(MaxTrans)) i_aw_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (aw_push),
    .wdata (slv_req_i.aw.id),
    .pop   (w_last_hs),
    .rdata (aw_head_id),
    .full  (aw_full),
    .empty (aw_empty)
  );

  // B register: loaded on the last W beat, held until the initiator takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_vld_p1 <= 1'b0;
      b_id_p1  <= '0;
    end else if (w_last_hs) begin
      b_vld_p1 <= 1'b1;
      b_id_p1  <= aw_head_id;
    end else if (slv_req_i.b_ready) begin
      b_vld_p1 <= 1'b0;
    end
  end

  // ---- read path: AR {id,len} FIFO -> R beat generator ----
  assign ar_push     = slv_req_i.ar_valid && !ar_full;
  assign ar_head_id  = ar_head[AxiIdWidth+7:8];
  assign ar_head_len = ar_head[7:0];
  assign r_last      = (r_cnt == ar_head_len);
  assign r_hs        = !ar_empty && slv_req_i.r_ready;

  axi_err_resp_fifo #(.Width(AxiIdWidth + 8), .Depth(MaxTrans)) i_ar_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (ar_push),
    .wdata ({slv_req_i.ar.id, slv_req_i.ar.len}),
    .pop   (r_hs && r_last),
    .rdata (ar_head),
    .full  (ar_full),
    .empty (ar_empty)
  );

  // Beat counter: 8 bits so len=255 runs the full 256 beats before wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 8'd0;
    end else if (r_hs) begin
      r_cnt <= r_last ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Response assembly; payload fields read as zero whenever not valid.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = !aw_full;
    slv_resp_o.ar_ready = !ar_full;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_vld_p1;
    if (b_vld_p1) begin
      slv_resp_o.b.id   = b_id_p1;
      slv_resp_o.b.resp = Resp;
    end
    slv_resp_o.r_valid = !ar_empty;
    if (!ar_empty) begin
      slv_resp_o.r.id   = ar_head_id;
      slv_resp_o.r.data = RespDataFit;
      slv_resp_o.r.resp = Resp;
      slv_resp_o.r.last = r_last;
    end
  end

  if (MaxTrans < 1) begin : g_bad_depth
    $error("axi_err_resp: MaxTrans must be at least 1");
  end

  a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_resp_o.b_valid && !slv_req_i.b_ready |=> slv_resp_o.b_valid && $stable(slv_resp_o.b));
  a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_resp_o.r_valid && !slv_req_i.r_ready |=> slv_resp_o.r_valid && $stable(slv_resp_o.r));
  a_no_orphan_w: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(slv_req_i.w_valid && slv_resp_o.w_ready && aw_empty));
endmodule

// File: doc/axi_err_resp.md
# axi_err_resp

AXI4 terminating subordinate: accepts every read and write transaction on its request port and completes each one with a fixed error response (default DECERR), honouring burst length and ID ordering. It sits at the default/unmapped port of the crossbar and demux and as a sink for isolated ports, so any initiator reaching it sees protocol-compliant completion instead of a hang.

## Interface
- `AxiIdWidth`, 4: ID width of the subordinate port.
- `AxiDataWidth`, 64: data width; `RespData` is truncated or zero-extended to this width.
- `axi_req_t`, logic: AXI4 request struct (AW, W, AR, B ready, R ready).
- `axi_resp_t`, logic: AXI4 response struct (AW/W/AR ready, B, R).
- `Resp`, 2'b11: value driven on `b.resp` and `r.resp`.
- `RespData`, 64'hCA11AB1EBADCAB1E: value driven on `r.data`.
- `MaxTrans`, 4: depth of each of the write-ID and read-ID/len FIFOs (≥1).
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `slv_req_i`  in  axi_req_t  request from the upstream initiator.
- `slv_resp_o`  out  axi_resp_t  response to the upstream initiator.

## Operation
- Write path: AW FIFO (MaxTrans × AxiIdWidth). `aw_ready` = AW FIFO not full. Address, size, burst, cache, prot, qos, region, user are ignored.
- `w_ready` high only while the AW FIFO is non-empty; W beats are discarded (data, strb, user ignored).
- A W beat with `w.last` is accepted only if the B register is free or is being emptied in the same cycle (`b_valid && b_ready`). On that handshake: pop AW FIFO, load B register with the popped ID, `b.resp = Resp`, `b_valid = 1`.
- B register holds valid and contents stable until `b_ready`.
- Read path: AR FIFO (MaxTrans × (AxiIdWidth + 8)) storing ID and `ar.len`. `ar_ready` = AR FIFO not full.
- R generator: 8-bit beat counter. While the AR FIFO is non-empty, drive `r_valid = 1`, `r.id` = head ID, `r.data = RespData`, `r.resp = Resp`, `r.last` = (counter == head len), `r.user = 0`. Counter increments on each R handshake; on the `r.last` handshake the counter returns to 0 and the FIFO pops.
- Read and write paths are fully independent. Responses are returned in acceptance order per path, regardless of ID.
- Atomic operations (`aw.atop` ≠ 0) are out of scope and must not be issued to this block; no R beats are produced for them.

## Timing
- Reset values: `aw_ready = 1`, `ar_ready = 1`, `w_ready = 0`, `b_valid = 0`, `r_valid = 0`, counter = 0, FIFOs empty, all response fields 0.
- FIFOs do not fall through. AW handshake in cycle N gives earliest W acceptance in N+1. AR handshake in cycle N gives first `r_valid` in N+1.
- `w.last` handshake in cycle N gives `b_valid` in N+1. Back-to-back B every cycle when `b_ready` is held high.
- R sustains one beat per cycle, including across bursts: the last beat of burst k is followed by beat 0 of burst k+1 in the next cycle.
- Ready signals do not depend combinationally on the same-channel valid. `w_ready` depends combinationally on `b_ready`.
- Full FIFO with a simultaneous pop: `aw_ready` and `ar_ready` reflect the registered full flag only, with no same-cycle bypass.
- `len = 255` produces 256 beats; the counter must not wrap early.
- Asserting `rst_ni` mid-burst aborts all outstanding transactions immediately and returns every output to its reset value asynchronously.
- Assertions (translate_off, non-Verilator): stable B/R payload while valid && !ready; no W handshake while the AW FIFO is empty; `MaxTrans ≥ 1`.

## Test plan
- Single write: AW id=3 len=0, then W last with `b_ready = 1` -> one B with id=3, resp=2'b11, in the cycle after the W handshake.
- Read burst: AR id=5 len=3, `r_ready = 1` -> four consecutive R beats, id=5, data=0xCA11AB1EBADCAB1E, resp=2'b11, `last` only on beat 4.
- Ordering and full: four ARs with ids 1–4 and len=0, `r_ready = 0` -> `ar_ready` low after the 4th. Release `r_ready` -> R ids 1,2,3,4 in order, and `ar_ready` rises again.
- B backpressure: two AW+W bursts with `b_ready = 0` -> first B is held stable, second `w.last` is not accepted. Raise `b_ready` -> second B follows in the next cycle.
- W before AW: W beats presented with no AW -> `w_ready` stays 0. Issue AW -> W is accepted from the next cycle.
- Max length and reset: AR len=255 -> exactly 256 beats. Repeat, pull `rst_ni` low at beat 100 -> `r_valid` drops immediately, and after release a new AR len=0 gives one beat with `last = 1`.
